// File: rtl/axis_pixel_receiver.sv
// Streaming front end of the KxK median filter: K-1 line buffers feeding a KxK
// register window, with a per-window valid strobe and a first-window-of-frame strobe.
module axis_pixel_receiver #(
  parameter int DATA_WIDTH      = 8,
  parameter int KERNEL_SIZE     = 5,
  parameter int MAX_IMAGE_WIDTH = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  input  logic [31:0]           IMAGE_WIDTH,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  input  logic                  i_start_of_frame,
  output logic [DATA_WIDTH-1:0] o_image_kernel_buffer [KERNEL_SIZE][KERNEL_SIZE],
  output logic                  o_data_valid,
  output logic                  o_start_of_frame
);

  localparam int K  = KERNEL_SIZE;
  localparam int CW = $clog2(MAX_IMAGE_WIDTH);
  localparam int RW = $clog2(KERNEL_SIZE);
  localparam logic [RW-1:0] ROW_LAST  = RW'(K - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);

  logic [DATA_WIDTH-1:0] lb_q  [K-1][MAX_IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] win_q [K][K];

  logic          armed_q;
  logic          sof_pend_q;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic          accept;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          col_last;
  logic          win_hit;

  // A SOF pixel is always (row 0, col 0), regardless of where the counters were.
  assign accept   = i_data_valid && (armed_q || i_start_of_frame);
  assign cur_col  = i_start_of_frame ? '0 : col_q;
  assign cur_row  = i_start_of_frame ? '0 : row_q;
  assign col_last = (32'(cur_col) == (IMAGE_WIDTH - 32'd1));
  assign win_hit  = accept && (cur_row == ROW_LAST) && (cur_col >= COL_FIRST);

  always_comb begin
    col_d = col_last ? '0 : cur_col + CW'(1);
    row_d = cur_row;
    if (col_last && (cur_row != ROW_LAST)) begin
      row_d = cur_row + RW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_aresetn) begin
      armed_q          <= 1'b0;
      sof_pend_q       <= 1'b0;
      col_q            <= '0;
      row_q            <= '0;
      o_data_valid     <= 1'b0;
      o_start_of_frame <= 1'b0;
    end else begin
      o_data_valid     <= win_hit;
      o_start_of_frame <= win_hit && sof_pend_q;
      if (accept) begin
        armed_q <= 1'b1;
        col_q   <= col_d;
        row_q   <= row_d;
        if (i_start_of_frame) begin
          sof_pend_q <= 1'b1;
        end else if (win_hit) begin
          sof_pend_q <= 1'b0;
        end
      end
    end
  end

  // Line buffers are plain RAM: no reset, read-before-write at the current column.
  always_ff @(posedge i_clk) begin
    if (i_aresetn && accept) begin
      for (int r = 0; r < K - 2; r++) begin
        lb_q[r][cur_col] <= lb_q[r+1][cur_col];
      end
      lb_q[K-2][cur_col] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_aresetn) begin
      for (int r = 0; r < K; r++) begin
        for (int j = 0; j < K; j++) begin
          win_q[r][j] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int j = 0; j < K - 1; j++) begin
          win_q[r][j] <= win_q[r][j+1];
        end
      end
      for (int r = 0; r < K - 1; r++) begin
        win_q[r][K-1] <= lb_q[r][cur_col];
      end
      win_q[K-1][K-1] <= i_data;
    end
  end

  assign o_image_kernel_buffer = win_q;

endmodule

// File: tb/tb_axis_pixel_receiver.sv
// Directed bench for axis_pixel_receiver: raster streams with hand-derived window
// contents, stalls, mid-frame SOF, mid-frame reset and a full-width line buffer.
module tb_axis_pixel_receiver;

  localparam int DW   = 8;
  localparam int K    = 5;
  localparam int MAXW = 4096;

  logic          clk = 1'b0;
  logic          aresetn;
  logic [31:0]   image_width;
  logic [DW-1:0] data;
  logic          data_valid;
  logic          sof_in;
  logic [DW-1:0] win [K][K];
  logic          dv_out;
  logic          sof_out;

  int n_pass   = 0;
  int n_fail   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  axis_pixel_receiver #(
    .DATA_WIDTH(DW), .KERNEL_SIZE(K), .MAX_IMAGE_WIDTH(MAXW)
  ) dut (
    .i_clk                 (clk),
    .i_aresetn             (aresetn),
    .IMAGE_WIDTH           (image_width),
    .i_data                (data),
    .i_data_valid          (data_valid),
    .i_start_of_frame      (sof_in),
    .o_image_kernel_buffer (win),
    .o_data_valid          (dv_out),
    .o_start_of_frame      (sof_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic drive(input logic v, input logic s, input logic [DW-1:0] d);
    data_valid = v;
    sof_in     = s;
    data       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_win_zero(input string tag);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        chk($sformatf("%s[%0d][%0d]", tag, r, c), 32'(win[r][c]), 32'd0);
  endtask

  // Window expected for the pixel at (row, col) of a stream whose value is base + index.
  task automatic chk_win(input int w, input int base, input int row, input int col);
    logic [DW-1:0] e;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        e = DW'(base + (row - K + 1 + r) * w + (col - K + 1 + c));
        chk($sformatf("win[%0d][%0d] px(%0d,%0d)", r, c, row, col), 32'(win[r][c]), 32'(e));
      end
  endtask

  task automatic run_frame(input int w, input int base, input int npix, input int gap_at,
                           output int nv, output int ns);
    int  row, col;
    logic exp_v, exp_s;
    nv = 0;
    ns = 0;
    image_width = 32'(w);
    for (int p = 0; p < npix; p++) begin
      if (p == gap_at && p > 0) begin
        for (int g = 0; g < 3; g++) begin
          drive(1'b0, 1'b0, 8'hEE);
          chk("gap_dv", 32'(dv_out), 32'd0);
          chk("gap_sof", 32'(sof_out), 32'd0);
          chk("gap_hold", 32'(win[K-1][K-1]), 32'(DW'(base + p - 1)));
        end
      end
      drive(1'b1, p == 0, DW'(base + p));
      row   = p / w;
      col   = p % w;
      exp_v = (row >= K - 1) && (col >= K - 1);
      exp_s = (row == K - 1) && (col == K - 1);
      chk($sformatf("dv px%0d", p), 32'(dv_out), 32'(exp_v));
      chk($sformatf("sof px%0d", p), 32'(sof_out), 32'(exp_s));
      if (dv_out) nv++;
      if (sof_out) ns++;
      if (exp_v) chk_win(w, base, row, col);
    end
    data_valid = 1'b0;
    sof_in     = 1'b0;
  endtask

  initial begin
    int nv, ns;
    aresetn     = 1'b0;
    image_width = 32'd8;
    data        = '0;
    data_valid  = 1'b0;
    sof_in      = 1'b0;

    // Reset held for two clocks while valid SOF pixels are driven.
    drive(1'b1, 1'b1, 8'h55);
    drive(1'b1, 1'b1, 8'h66);
    chk_win_zero("rst_win");
    chk("rst_dv", 32'(dv_out), 32'd0);
    chk("rst_sof", 32'(sof_out), 32'd0);

    // Pixels before the first SOF are ignored.
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'hAA);
      chk("presof_dv", 32'(dv_out), 32'd0);
    end
    chk_win_zero("presof_win");

    // 8x8 frame, values 0..63, 3-cycle stall mid-row before pixel 35.
    run_frame(8, 0, 64, 35, nv, ns);
    chk("f1_valid_count", 32'(nv), 32'd16);
    chk("f1_sof_count", 32'(ns), 32'd1);

    // Frame cut after row 6, then a new frame starts immediately (mid-frame SOF).
    run_frame(8, 100, 56, -1, nv, ns);
    chk("f2_valid_count", 32'(nv), 32'd12);
    chk("f2_sof_count", 32'(ns), 32'd1);
    run_frame(8, 200, 64, -1, nv, ns);
    chk("f3_valid_count", 32'(nv), 32'd16);
    chk("f3_sof_count", 32'(ns), 32'd1);

    // Reset mid-frame: further pixels without SOF must produce nothing.
    run_frame(8, 50, 20, -1, nv, ns);
    chk("f4_valid_count", 32'(nv), 32'd0);
    aresetn = 1'b0;
    drive(1'b1, 1'b0, 8'h77);
    chk("midrst_dv", 32'(dv_out), 32'd0);
    chk("midrst_win44", 32'(win[K-1][K-1]), 32'd0);
    aresetn = 1'b1;
    nv = 0;
    for (int i = 0; i < 48; i++) begin
      drive(1'b1, 1'b0, DW'(i));
      chk("postrst_dv", 32'(dv_out), 32'd0);
      if (dv_out) nv++;
    end
    chk("postrst_valid_count", 32'(nv), 32'd0);
    chk("postrst_win44", 32'(win[K-1][K-1]), 32'd0);

    // Full-depth line buffers: first window after pixel 4*4096+4.
    run_frame(MAXW, 0, 4 * MAXW + 5, -1, nv, ns);
    chk("w4096_valid_count", 32'(nv), 32'd1);
    chk("w4096_sof_count", 32'(ns), 32'd1);

    drive(1'b0, 1'b0, 8'h00);
    chk("idle_dv", 32'(dv_out), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
